// File: rtl/instr_prefetch.sv
// rtl/instr_prefetch.sv - instruction prefetch engine with credit and outstanding-request flow control
// Optional feature: define PREFETCH_PERF_CNT_EN to count dropped responses on discard_cnt_o.
module instr_prefetch #(
  parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 8,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        fifo_push_o,
  output logic [63:0] fifo_data_o,
  output logic        fifo_flush_o,
  input  logic        fifo_pop_i,
  output logic [15:0] discard_cnt_o
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CREDITS_FULL = CW'(FIFO_DEPTH);
  localparam logic [OW-1:0] OUT_MAX      = OW'(MAX_OUTSTANDING);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

  state_e        state_q;
  logic          mem_req_q;
  logic [31:0]   pc_q;
  logic [31:0]   pend_pc_q;
  logic          redir_pend_q;
  logic [31:0]   rsp_pc_q;
  logic [CW-1:0] credits_q, credits_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] discard_q, discard_d;
  logic          gnt_acc;
  logic          can_fetch_now;
  logic          can_fetch_next;

  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = pc_q;
  assign gnt_acc      = mem_req_q & mem_gnt_i;
  // Reset gating keeps push/flush quiet while rst_i is asserted, even with live inputs.
  assign fifo_push_o  = mem_rvalid_i & (discard_q == '0) & ~redirect_i & ~rst_i;
  assign fifo_data_o  = {rsp_pc_q, mem_rdata_i};
  assign fifo_flush_o = redirect_i & ~rst_i;

  assign can_fetch_now  = (credits_q != '0) && (outstanding_q < OUT_MAX);
  assign can_fetch_next = (credits_d != '0) && (outstanding_d < OUT_MAX);

  // Next-state values of the credit, in-flight and discard counters
  always_comb begin
    outstanding_d = outstanding_q;
    if (gnt_acc)
      outstanding_d = outstanding_d + OW'(1);
    if (mem_rvalid_i && (outstanding_q != '0))
      outstanding_d = outstanding_d - OW'(1);

    credits_d = credits_q;
    if (redirect_i)
      credits_d = CREDITS_FULL;
    else if (fifo_pop_i && !gnt_acc && (credits_q < CREDITS_FULL))
      credits_d = credits_q + CW'(1);
    else if (gnt_acc && !fifo_pop_i)
      credits_d = credits_q - CW'(1);

    discard_d = discard_q;
    if (redirect_i)
      discard_d = outstanding_d;
    else begin
      if (mem_rvalid_i && (discard_q != '0))
        discard_d = discard_d - OW'(1);
      // The grant that was pending across a redirect fetches a stale address
      if (gnt_acc && redir_pend_q)
        discard_d = discard_d + OW'(1);
    end
  end

  // Request FSM with fetch PC and deferred-redirect bookkeeping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      pc_q         <= BOOT_ADDR;
      pend_pc_q    <= BOOT_ADDR;
      redir_pend_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (can_fetch_now && !redirect_i) begin
            state_q   <= WAIT;
            mem_req_q <= 1'b1;
          end
        end
        WAIT: begin
          if (mem_gnt_i && !can_fetch_next) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase

      if (redirect_i) begin
        // An un-granted request must keep its address, so the target waits
        if ((state_q == WAIT) && !mem_gnt_i) begin
          pend_pc_q    <= redirect_pc_i;
          redir_pend_q <= 1'b1;
        end else begin
          pc_q         <= redirect_pc_i;
          redir_pend_q <= 1'b0;
        end
      end else if (gnt_acc) begin
        pc_q         <= redir_pend_q ? pend_pc_q : pc_q + 32'd4;
        redir_pend_q <= 1'b0;
      end
    end
  end

  // Counter registers and the PC tag of the next pushed response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      credits_q     <= CREDITS_FULL;
      outstanding_q <= '0;
      discard_q     <= '0;
      rsp_pc_q      <= BOOT_ADDR;
    end else begin
      credits_q     <= credits_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      if (redirect_i)
        rsp_pc_q <= redirect_pc_i;
      else if (fifo_push_o)
        rsp_pc_q <= rsp_pc_q + 32'd4;
    end
  end

`ifdef PREFETCH_PERF_CNT_EN
  logic        rsp_drop;
  logic [15:0] discard_cnt_q;

  assign rsp_drop      = mem_rvalid_i & ((discard_q != '0) | redirect_i);
  assign discard_cnt_o = discard_cnt_q;

  // Saturating count of responses dropped after redirects
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      discard_cnt_q <= 16'h0000;
    else if (rsp_drop && (discard_cnt_q != 16'hFFFF))
      discard_cnt_q <= discard_cnt_q + 16'd1;
  end
`else
  assign discard_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
// tb/tb_instr_prefetch.sv - directed and randomized self-checking bench for instr_prefetch
`timescale 1ns/1ps
module tb_instr_prefetch;

  localparam int          DEPTH = 8;
  localparam int          MAXO  = 4;
  localparam logic [31:0] BOOT  = 32'h0000_0000;
`ifdef PREFETCH_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        fifo_push_o;
  logic [63:0] fifo_data_o;
  logic        fifo_flush_o;
  logic        fifo_pop_i;
  logic [15:0] discard_cnt_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  instr_prefetch dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .fifo_push_o   (fifo_push_o),
    .fifo_data_o   (fifo_data_o),
    .fifo_flush_o  (fifo_flush_o),
    .fifo_pop_i    (fifo_pop_i),
    .discard_cnt_o (discard_cnt_o)
  );

  // Memory contents: a fixed scramble of the word address
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  // Simple in-order memory for directed scenarios
  logic [31:0] mem_q[$];
  logic [31:0] gnt_log[$];
  logic [63:0] push_log[$];

  task automatic drive(input logic gnt, input logic rsp);
    mem_gnt_i    = gnt;
    mem_rvalid_i = rsp && (mem_q.size() > 0);
    mem_rdata_i  = (mem_q.size() > 0) ? word_of(mem_q[0]) : 32'h0;
  endtask

  task automatic tick();
    logic [31:0] g;
    logic [31:0] junk;
    logic        got;
    #1;
    got = mem_req_o && mem_gnt_i;
    g   = mem_addr_o;
    if (fifo_push_o) push_log.push_back(fifo_data_o);
    if (mem_rvalid_i) junk = mem_q.pop_front();
    @(negedge clk_i);
    if (got) begin
      mem_q.push_back(g);
      gnt_log.push_back(g);
    end
  endtask

  task automatic apply_reset();
    rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0; fifo_pop_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    mem_q.delete(); gnt_log.delete(); push_log.delete();
  endtask

  task automatic test_reset();
    rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h1234; fifo_pop_i = 1'b1;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk_i);
    #1;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req_o); end
    checks++; if (fifo_push_o !== 1'b0) begin errors++; $display("FAIL reset_push: got %b want 0", fifo_push_o); end
    checks++; if (discard_cnt_o !== 16'h0) begin errors++; $display("FAIL reset_discard_cnt: got %0d want 0", discard_cnt_o); end
    redirect_i = 1'b1; #1;
    checks++; if (fifo_flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", fifo_flush_o); end
    apply_reset();
    drive(1'b1, 1'b0); #1;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_idle_req: got %b want 0", mem_req_o); end
    @(posedge clk_i); #1;
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", mem_req_o); end
    checks++; if (mem_addr_o !== BOOT) begin errors++; $display("FAIL first_addr: got %h want %h", mem_addr_o, BOOT); end
  endtask

  task automatic test_boot_burst();
    apply_reset();
    for (int i = 0; i < 30; i++) begin drive(1'b1, 1'b1); tick(); end
    checks++; if (gnt_log.size() != DEPTH) begin errors++; $display("FAIL burst_grants: got %0d want %0d", gnt_log.size(), DEPTH); end
    for (int i = 0; i < gnt_log.size(); i++) begin
      checks++; if (gnt_log[i] !== BOOT + 32'(4*i)) begin errors++; $display("FAIL burst_addr[%0d]: got %h want %h", i, gnt_log[i], BOOT + 32'(4*i)); end
    end
    checks++; if (push_log.size() != DEPTH) begin errors++; $display("FAIL burst_pushes: got %0d want %0d", push_log.size(), DEPTH); end
    for (int i = 0; i < push_log.size(); i++) begin
      checks++;
      if (push_log[i] !== {BOOT + 32'(4*i), word_of(BOOT + 32'(4*i))}) begin
        errors++; $display("FAIL burst_push[%0d]: got %h want %h", i, push_log[i], {BOOT + 32'(4*i), word_of(BOOT + 32'(4*i))});
      end
    end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL burst_credit_stop: got req %b want 0", mem_req_o); end
    gnt_log.delete(); push_log.delete();
    fifo_pop_i = 1'b1; drive(1'b1, 1'b1); tick(); fifo_pop_i = 1'b0;
    for (int i = 0; i < 10; i++) begin drive(1'b1, 1'b1); tick(); end
    checks++; if (gnt_log.size() != 1) begin errors++; $display("FAIL pop_grants: got %0d want 1", gnt_log.size()); end
    checks++; if (gnt_log.size() > 0 && gnt_log[0] !== 32'h20) begin errors++; $display("FAIL pop_addr: got %h want 00000020", gnt_log[0]); end
    checks++; if (push_log.size() != 1 || push_log[0][63:32] !== 32'h20) begin errors++; $display("FAIL pop_push: got %0d pushes want 1 at pc 00000020", push_log.size()); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL pop_stop: got req %b want 0", mem_req_o); end
  endtask

  task automatic test_outstanding_limit();
    apply_reset();
    for (int i = 0; i < 15; i++) begin drive(1'b1, 1'b0); tick(); end
    checks++; if (gnt_log.size() != MAXO) begin errors++; $display("FAIL outst_grants: got %0d want %0d", gnt_log.size(), MAXO); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL outst_req: got %b want 0", mem_req_o); end
    for (int i = 0; i < gnt_log.size(); i++) begin
      checks++; if (gnt_log[i] !== 32'(4*i)) begin errors++; $display("FAIL outst_addr[%0d]: got %h want %h", i, gnt_log[i], 32'(4*i)); end
    end
  endtask

  task automatic test_redirect_flush();
    apply_reset();
    for (int i = 0; i < 20; i++) begin drive(1'b1, 1'b1); tick(); end
    fifo_pop_i = 1'b1;
    for (int i = 0; i < 3; i++) begin drive(1'b0, 1'b0); tick(); end
    fifo_pop_i = 1'b0;
    gnt_log.delete(); push_log.delete();
    for (int i = 0; i < 8; i++) begin drive(1'b1, 1'b0); tick(); end
    checks++; if (gnt_log.size() != 3 || mem_req_o !== 1'b0) begin errors++; $display("FAIL flush_setup: got %0d grants req %b want 3 grants req 0", gnt_log.size(), mem_req_o); end
    gnt_log.delete(); push_log.delete();
    redirect_i = 1'b1; redirect_pc_i = 32'h100; drive(1'b0, 1'b0); #1;
    checks++; if (fifo_flush_o !== 1'b1) begin errors++; $display("FAIL flush_strobe: got %b want 1", fifo_flush_o); end
    tick(); redirect_i = 1'b0;
    for (int i = 0; i < 14; i++) begin drive(1'b1, 1'b1); tick(); end
    checks++; if (push_log.size() == 0) begin errors++; $display("FAIL flush_no_push: got 0 pushes want at least 1"); end
    for (int i = 0; i < push_log.size(); i++) begin
      checks++; if (push_log[i][63:32] !== 32'h100 + 32'(4*i)) begin errors++; $display("FAIL flush_push_pc[%0d]: got %h want %h", i, push_log[i][63:32], 32'h100 + 32'(4*i)); end
    end
    checks++; if (discard_cnt_o !== (PERF_EN ? 16'd3 : 16'd0)) begin errors++; $display("FAIL flush_discard_cnt: got %0d want %0d", discard_cnt_o, PERF_EN ? 3 : 0); end
  endtask

  task automatic test_redirect_pending();
    apply_reset();
    redirect_i = 1'b1; redirect_pc_i = 32'h40; drive(1'b0, 1'b0); tick(); redirect_i = 1'b0;
    for (int i = 0; i < 3; i++) begin drive(1'b0, 1'b0); tick(); end
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h40) begin errors++; $display("FAIL pend_setup: got req %b addr %h want req 1 addr 00000040", mem_req_o, mem_addr_o); end
    redirect_i = 1'b1; redirect_pc_i = 32'h200; drive(1'b0, 1'b0); #1;
    checks++; if (fifo_flush_o !== 1'b1) begin errors++; $display("FAIL pend_flush: got %b want 1", fifo_flush_o); end
    tick(); redirect_i = 1'b0;
    for (int i = 0; i < 3; i++) begin drive(1'b0, 1'b0); tick(); end
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h40) begin errors++; $display("FAIL pend_hold: got req %b addr %h want req 1 addr 00000040", mem_req_o, mem_addr_o); end
    for (int i = 0; i < 10; i++) begin drive(1'b1, 1'b1); tick(); end
    checks++; if (gnt_log.size() < 2 || gnt_log[0] !== 32'h40 || gnt_log[1] !== 32'h200) begin errors++; $display("FAIL pend_grant_order: got %0d grants first %h want 00000040 then 00000200", gnt_log.size(), gnt_log.size() > 0 ? gnt_log[0] : 32'hx); end
    checks++; if (push_log.size() == 0 || push_log[0][63:32] !== 32'h200) begin errors++; $display("FAIL pend_first_push: got %0d pushes want first pc 00000200", push_log.size()); end
    checks++; if (discard_cnt_o !== (PERF_EN ? 16'd1 : 16'd0)) begin errors++; $display("FAIL pend_discard_cnt: got %0d want %0d", discard_cnt_o, PERF_EN ? 1 : 0); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b1); tick(); end
    drive(1'b1, 1'b1); #1;
    checks++; if (mem_req_o !== 1'b1 || fifo_push_o !== 1'b1) begin errors++; $display("FAIL areset_pre: got req %b push %b want 1 1", mem_req_o, fifo_push_o); end
    #1 rst_i = 1'b1; #1;
    checks++; if (mem_req_o !== 1'b0 || fifo_push_o !== 1'b0) begin errors++; $display("FAIL areset_now: got req %b push %b want 0 0", mem_req_o, fifo_push_o); end
    apply_reset();
    for (int i = 0; i < 10; i++) begin drive(1'b1, 1'b1); tick(); end
    checks++; if (gnt_log.size() == 0 || gnt_log[0] !== BOOT) begin errors++; $display("FAIL areset_restart_addr: got %0d grants want first at %h", gnt_log.size(), BOOT); end
    checks++; if (push_log.size() == 0 || push_log[0][63:32] !== BOOT) begin errors++; $display("FAIL areset_restart_push: got %0d pushes want first pc %h", push_log.size(), BOOT); end
  endtask

  // Reference model state: every in-flight fetch carries its address and a stale tag
  logic [31:0] inf_addr[$];
  bit          inf_stale[$];
  bit          m_req, m_pend;
  logic [31:0] m_pc, m_pend_pc;
  int          m_credits, m_fifo, m_drops;

  task automatic test_random_traffic();
    logic        exp_push;
    logic [15:0] exp_cnt;
    logic        gnt_acc;
    logic [31:0] a;
    bit          s;
    int          old_out, cred_old, occ;
    apply_reset();
    m_req = 1'b0; m_pend = 1'b0; m_pc = BOOT; m_pend_pc = BOOT;
    m_credits = DEPTH; m_fifo = 0; m_drops = 0; occ = 0;
    inf_addr.delete(); inf_stale.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      redirect_i    = ($urandom_range(0, 19) == 0);
      redirect_pc_i = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3))
                                                  : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      mem_gnt_i     = ($urandom_range(0, 3) != 0);
      mem_rvalid_i  = (inf_addr.size() > 0) && ($urandom_range(0, 2) != 0);
      mem_rdata_i   = mem_rvalid_i ? word_of(inf_addr[0]) : $urandom();
      fifo_pop_i    = (m_fifo > 0) && ($urandom_range(0, 1) == 1);
      #1;
      exp_push = mem_rvalid_i && !inf_stale[0] && !redirect_i;
      exp_cnt  = PERF_EN ? ((m_drops > 65535) ? 16'hFFFF : 16'(m_drops)) : 16'h0;
      checks++; if (mem_req_o !== m_req) begin errors++; $display("FAIL rnd_req @%0d: got %b want %b", cyc, mem_req_o, m_req); end
      if (m_req) begin
        checks++; if (mem_addr_o !== m_pc) begin errors++; $display("FAIL rnd_addr @%0d: got %h want %h", cyc, mem_addr_o, m_pc); end
      end
      checks++; if (fifo_flush_o !== redirect_i) begin errors++; $display("FAIL rnd_flush @%0d: got %b want %b", cyc, fifo_flush_o, redirect_i); end
      checks++; if (fifo_push_o !== exp_push) begin errors++; $display("FAIL rnd_push @%0d: got %b want %b", cyc, fifo_push_o, exp_push); end
      if (exp_push) begin
        checks++; if (fifo_data_o !== {inf_addr[0], mem_rdata_i}) begin errors++; $display("FAIL rnd_data @%0d: got %h want %h", cyc, fifo_data_o, {inf_addr[0], mem_rdata_i}); end
      end
      checks++; if (discard_cnt_o !== exp_cnt) begin errors++; $display("FAIL rnd_discard_cnt @%0d: got %0d want %0d", cyc, discard_cnt_o, exp_cnt); end
      occ = fifo_flush_o ? 0 : occ + int'(fifo_push_o) - int'(fifo_pop_i);
      checks++; if (occ > DEPTH) begin errors++; $display("FAIL rnd_fifo_overflow @%0d: got occupancy %0d want <= %0d", cyc, occ, DEPTH); end

      gnt_acc  = m_req && mem_gnt_i;
      old_out  = inf_addr.size();
      cred_old = m_credits;
      if (mem_rvalid_i) begin
        a = inf_addr.pop_front();
        s = inf_stale.pop_front();
        if (s || redirect_i) m_drops++;
        else m_fifo++;
      end
      if (redirect_i) begin
        foreach (inf_stale[k]) inf_stale[k] = 1'b1;
        m_fifo = 0;
      end else if (fifo_pop_i) begin
        m_fifo--;
      end
      if (gnt_acc) begin
        inf_addr.push_back(m_pc);
        inf_stale.push_back(redirect_i || m_pend);
      end
      if (redirect_i) begin
        m_credits = DEPTH;
        if (m_req && !mem_gnt_i) begin
          m_pend = 1'b1; m_pend_pc = redirect_pc_i;
        end else begin
          m_pc = redirect_pc_i; m_pend = 1'b0;
        end
      end else begin
        m_credits = m_credits + int'(fifo_pop_i) - int'(gnt_acc);
        if (gnt_acc) begin
          m_pc   = m_pend ? m_pend_pc : m_pc + 32'd4;
          m_pend = 1'b0;
        end
      end
      if (m_req) m_req = gnt_acc ? (m_credits > 0 && inf_addr.size() < MAXO) : 1'b1;
      else       m_req = (cred_old > 0) && (old_out < MAXO) && !redirect_i;
      @(negedge clk_i);
    end
  endtask

  initial begin
    rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0; fifo_pop_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    test_reset();
    test_boot_burst();
    test_outstanding_limit();
    test_redirect_flush();
    test_redirect_pending();
    test_async_reset();
    test_random_traffic();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
